// File: rtl/tmr_vote_pkg.sv
// tmr_vote_pkg -- shared definitions for the TMR vote controller.
//   state_e        : controller FSM states
//   CH_A/CH_B/CH_C : channel index constants (bit position in per-channel vectors)
//   CNT_W          : width of the consecutive-mismatch counters
//   ERR_W          : width of the optional total-mismatch counters (TMR_ERRCNT_EN)
package tmr_vote_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_VOTE    = 2'd2,
    ST_OUT     = 2'd3
  } state_e;

  localparam int unsigned CH_A  = 0;
  localparam int unsigned CH_B  = 1;
  localparam int unsigned CH_C  = 2;
  localparam int unsigned NCH   = 3;

  localparam int unsigned CNT_W = 8;
  localparam int unsigned ERR_W = 8;

endpackage

// File: rtl/tmr_bitvote.sv
// tmr_bitvote -- combinational W-bit bitwise 2-of-3 majority.
//   a_i, b_i, c_i : input  [W-1:0] redundant words
//   maj_o         : output [W-1:0] (a&b)|(a&c)|(b&c)
module tmr_bitvote #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [W-1:0] c_i,
  output logic [W-1:0] maj_o
);

  assign maj_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);

endmodule

// File: rtl/tmr_vote_ctrl.sv
// tmr_vote_ctrl -- collects one word from each of three redundant channels,
// votes them bitwise 2-of-3, and presents the result with per-channel
// mismatch flags and sticky fault tracking.
//
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   in_valid[2:0]     : per-channel word valid (bit0=a, bit1=b, bit2=c)
//   in_data_a/b/c     : channel words
//   in_ack[2:0]       : same-cycle pulse when a channel word is captured
//   out_valid         : voted result held until out_ready
//   out_ready         : consumer accepts result
//   out_data          : voted word
//   out_mismatch[2:0] : channel disagreed with out_data or was missing
//   out_timeout       : result formed after timeout with one channel missing
//   drop              : one-cycle pulse when a lone-word set is discarded
//   fault[2:0]        : sticky per-channel fault flags
//   err_cnt_a/b/c     : saturating total-mismatch counters (only with TMR_ERRCNT_EN)
//
// Build option: define TMR_ERRCNT_EN to add the err_cnt_* outputs.
module tmr_vote_ctrl
  import tmr_vote_pkg::*;
#(
  parameter int unsigned W            = 8,
  parameter int unsigned TIMEOUT      = 15,
  parameter int unsigned FAULT_THRESH = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [2:0]   in_valid,
  input  logic [W-1:0] in_data_a,
  input  logic [W-1:0] in_data_b,
  input  logic [W-1:0] in_data_c,
  output logic [2:0]   in_ack,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [2:0]   out_mismatch,
  output logic         out_timeout,
  output logic         drop,
  output logic [2:0]   fault
`ifdef TMR_ERRCNT_EN
  ,
  output logic [ERR_W-1:0] err_cnt_a,
  output logic [ERR_W-1:0] err_cnt_b,
  output logic [ERR_W-1:0] err_cnt_c
`endif
);

  localparam int unsigned TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  state_e                    state_q, state_d;
  logic [2:0]                cap_q, cap_d;
  logic [2:0][W-1:0]         word_q, word_d;
  logic [TW-1:0]             timer_q, timer_d;
  logic [2:0][CNT_W-1:0]     mcnt_q, mcnt_d;
  logic                      out_valid_q, out_valid_d;
  logic [W-1:0]              out_data_q, out_data_d;
  logic [2:0]                out_mm_q, out_mm_d;
  logic                      out_to_q, out_to_d;
  logic                      drop_q, drop_d;
  logic [2:0]                fault_q, fault_d;
`ifdef TMR_ERRCNT_EN
  logic [2:0][ERR_W-1:0]     err_q, err_d;
`endif

  logic [2:0]                accept;
  logic [2:0][W-1:0]         in_word;
  logic [2:0][W-1:0]         vote_in;
  logic [W-1:0]              voted;
  logic                      two_capt;

  assign in_word = {in_data_c, in_data_b, in_data_a};

  // Missing channels vote as zero.
  always_comb begin
    for (int unsigned i = 0; i < NCH; i++) begin
      vote_in[i] = cap_q[i] ? word_q[i] : '0;
    end
  end

  tmr_bitvote #(.W(W)) u_bitvote (
    .a_i   (vote_in[CH_A]),
    .b_i   (vote_in[CH_B]),
    .c_i   (vote_in[CH_C]),
    .maj_o (voted)
  );

  // Capture is only open while collecting; ack is the same-cycle capture strobe.
  assign accept = ((state_q == ST_IDLE) || (state_q == ST_COLLECT)) ? (in_valid & ~cap_q) : 3'b000;
  assign in_ack = rst ? 3'b000 : accept;

  always_comb begin
    state_d     = state_q;
    cap_d       = cap_q;
    word_d      = word_q;
    timer_d     = timer_q;
    mcnt_d      = mcnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_mm_d    = out_mm_q;
    out_to_d    = out_to_q;
    drop_d      = 1'b0;
    fault_d     = fault_q;
`ifdef TMR_ERRCNT_EN
    err_d       = err_q;
`endif
    two_capt    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cap_d = accept;
        for (int unsigned i = 0; i < NCH; i++) begin
          if (accept[i]) word_d[i] = in_word[i];
        end
        if (accept != 3'b000) begin
          timer_d = '0;
          state_d = (accept == 3'b111) ? ST_VOTE : ST_COLLECT;
        end
      end

      ST_COLLECT: begin
        cap_d = cap_q | accept;
        for (int unsigned i = 0; i < NCH; i++) begin
          if (accept[i]) word_d[i] = in_word[i];
        end
        // A word arriving on the expiry cycle still counts toward the set.
        two_capt = (cap_d[0] & cap_d[1]) | (cap_d[0] & cap_d[2]) | (cap_d[1] & cap_d[2]);
        if (cap_d == 3'b111) begin
          state_d = ST_VOTE;
        end else if (timer_q == TW'(TIMEOUT)) begin
          if (two_capt) begin
            state_d = ST_VOTE;
          end else begin
            drop_d  = 1'b1;
            cap_d   = '0;
            state_d = ST_IDLE;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      ST_VOTE: begin
        out_valid_d = 1'b1;
        out_data_d  = voted;
        out_to_d    = (cap_q != 3'b111);
        for (int unsigned i = 0; i < NCH; i++) begin
          out_mm_d[i] = ~cap_q[i] | (vote_in[i] != voted);
          if (out_mm_d[i]) begin
            if (mcnt_q[i] < CNT_W'(FAULT_THRESH)) mcnt_d[i] = mcnt_q[i] + 1'b1;
            if (mcnt_d[i] == CNT_W'(FAULT_THRESH)) fault_d[i] = 1'b1;
`ifdef TMR_ERRCNT_EN
            if (err_q[i] != '1) err_d[i] = err_q[i] + 1'b1;
`endif
          end else begin
            mcnt_d[i] = '0;
          end
        end
        state_d = ST_OUT;
      end

      ST_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          cap_d       = '0;
          state_d     = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cap_q       <= '0;
      word_q      <= '0;
      timer_q     <= '0;
      mcnt_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_mm_q    <= '0;
      out_to_q    <= 1'b0;
      drop_q      <= 1'b0;
      fault_q     <= '0;
`ifdef TMR_ERRCNT_EN
      err_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cap_q       <= cap_d;
      word_q      <= word_d;
      timer_q     <= timer_d;
      mcnt_q      <= mcnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_mm_q    <= out_mm_d;
      out_to_q    <= out_to_d;
      drop_q      <= drop_d;
      fault_q     <= fault_d;
`ifdef TMR_ERRCNT_EN
      err_q       <= err_d;
`endif
    end
  end

  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign out_mismatch = out_mm_q;
  assign out_timeout  = out_to_q;
  assign drop         = drop_q;
  assign fault        = fault_q;
`ifdef TMR_ERRCNT_EN
  assign err_cnt_a    = err_q[CH_A];
  assign err_cnt_b    = err_q[CH_B];
  assign err_cnt_c    = err_q[CH_C];
`endif

endmodule

// File: tb/tb_tmr_vote_ctrl.sv
// tb_tmr_vote_ctrl -- directed bench for tmr_vote_ctrl (W=8, TIMEOUT=4, FAULT_THRESH=3).
module tb_tmr_vote_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] in_valid;
  logic [7:0] in_data_a, in_data_b, in_data_c;
  logic [2:0] in_ack;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [2:0] out_mismatch;
  logic       out_timeout;
  logic       drop;
  logic [2:0] fault;
`ifdef TMR_ERRCNT_EN
  logic [7:0] err_cnt_a, err_cnt_b, err_cnt_c;
`endif

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  tmr_vote_ctrl #(.W(8), .TIMEOUT(4), .FAULT_THRESH(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_data_a    (in_data_a),
    .in_data_b    (in_data_b),
    .in_data_c    (in_data_c),
    .in_ack       (in_ack),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_mismatch (out_mismatch),
    .out_timeout  (out_timeout),
    .drop         (drop),
    .fault        (fault)
`ifdef TMR_ERRCNT_EN
    ,
    .err_cnt_a    (err_cnt_a),
    .err_cnt_b    (err_cnt_b),
    .err_cnt_c    (err_cnt_c)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one set at cycle t, check ack, then wait (bounded) for out_valid or drop.
  // lat is the number of cycles from t to the first cycle showing either.
  task automatic run_set(input string tag, input logic [2:0] v,
                         input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                         input logic [2:0] exp_ack, output int lat);
    in_valid  = v;
    in_data_a = a;
    in_data_b = b;
    in_data_c = c;
    #1;
    chk({tag, "_ack"}, 32'(in_ack), 32'(exp_ack));
    tick();
    in_valid = 3'b000;
    lat = 1;
    while (!out_valid && !drop && lat < 30) begin
      tick();
      lat++;
    end
  endtask

  task automatic accept_out(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_released"}, 32'(out_valid), 32'd0);
  endtask

  task automatic vote_full(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] c, input logic [7:0] exp_d,
                           input logic [2:0] exp_mm, input logic [2:0] exp_f);
    int lat;
    run_set(tag, 3'b111, a, b, c, 3'b111, lat);
    chk({tag, "_lat"},   32'(lat),          32'd2);
    chk({tag, "_data"},  32'(out_data),     32'(exp_d));
    chk({tag, "_mm"},    32'(out_mismatch), 32'(exp_mm));
    chk({tag, "_to"},    32'(out_timeout),  32'd0);
    chk({tag, "_fault"}, 32'(fault),        32'(exp_f));
    accept_out(tag);
  endtask

  initial begin
    int lat;
    int seen_drop;

    // Reset with all channels valid: reset must win, no ack.
    rst       = 1'b1;
    in_valid  = 3'b111;
    in_data_a = 8'h11;
    in_data_b = 8'h22;
    in_data_c = 8'h33;
    out_ready = 1'b0;
    tick();
    chk("rst_ack", 32'(in_ack), 32'd0);
    tick();
    rst      = 1'b0;
    in_valid = 3'b000;
    tick();
    chk("rst_valid", 32'(out_valid),    32'd0);
    chk("rst_data",  32'(out_data),     32'd0);
    chk("rst_mm",    32'(out_mismatch), 32'd0);
    chk("rst_to",    32'(out_timeout),  32'd0);
    chk("rst_drop",  32'(drop),         32'd0);
    chk("rst_fault", 32'(fault),        32'd0);

    // All agree; first cycle after capture must not yet show a result.
    in_valid  = 3'b111;
    in_data_a = 8'h5A;
    in_data_b = 8'h5A;
    in_data_c = 8'h5A;
    #1;
    chk("agree_ack", 32'(in_ack), 32'h7);
    tick();
    in_valid = 3'b000;
    chk("agree_t1_valid", 32'(out_valid), 32'd0);
    tick();
    chk("agree_t2_valid", 32'(out_valid),    32'd1);
    chk("agree_data",     32'(out_data),     32'h5A);
    chk("agree_mm",       32'(out_mismatch), 32'd0);
    chk("agree_to",       32'(out_timeout),  32'd0);
    accept_out("agree");

    // c wrong three votes in a row -> fault[c] on the third, then stays set.
    vote_full("cbad1", 8'h5A, 8'h5A, 8'hFF, 8'h5A, 3'b100, 3'b000);
    vote_full("cbad2", 8'h5A, 8'h5A, 8'hA5, 8'h5A, 3'b100, 3'b000);
    vote_full("cbad3", 8'h3C, 8'h3C, 8'h00, 8'h3C, 3'b100, 3'b100);
    vote_full("cgood", 8'h77, 8'h77, 8'h77, 8'h77, 3'b000, 3'b100);

    // Bitwise majority with all three differing: 11/22/33 -> 33, a and b disagree.
    vote_full("mix", 8'h11, 8'h22, 8'h33, 8'h33, 3'b011, 3'b100);

    // Two channels only: capture at t, COLLECT t+1..t+5, VOTE t+6, result t+7.
    run_set("tmo", 3'b011, 8'h0F, 8'h0F, 8'hAA, 3'b011, lat);
    chk("tmo_lat",  32'(lat),          32'd7);
    chk("tmo_data", 32'(out_data),     32'h0F);
    chk("tmo_to",   32'(out_timeout),  32'd1);
    chk("tmo_mm",   32'(out_mismatch), 32'b100);
    accept_out("tmo");

    // Single channel: discarded at expiry, drop pulse at t+6 for one cycle.
    run_set("drop", 3'b001, 8'h42, 8'h00, 8'h00, 3'b001, lat);
    chk("drop_lat",   32'(lat),       32'd6);
    chk("drop_pulse", 32'(drop),      32'd1);
    chk("drop_novld", 32'(out_valid), 32'd0);
    tick();
    chk("drop_once",  32'(drop),      32'd0);

    // Back-pressure: result held for 5 cycles, new words not acknowledged.
    run_set("stall", 3'b111, 8'h11, 8'h22, 8'h33, 3'b111, lat);
    chk("stall_lat", 32'(lat), 32'd2);
    for (int i = 0; i < 5; i++) begin
      in_valid  = 3'b111;
      in_data_a = 8'hC3;
      in_data_b = 8'hC3;
      in_data_c = 8'hC3;
      #1;
      chk("stall_ack",   32'(in_ack),       32'd0);
      chk("stall_valid", 32'(out_valid),    32'd1);
      chk("stall_data",  32'(out_data),     32'h33);
      chk("stall_mm",    32'(out_mismatch), 32'b011);
      tick();
    end
    in_valid = 3'b000;
    chk("stall_held", 32'(out_valid), 32'd1);
    accept_out("stall");

    // Reset in the middle of collecting: no drop, everything cleared.
    in_valid  = 3'b001;
    in_data_a = 8'h99;
    tick();
    in_valid = 3'b000;
    tick();
    rst      = 1'b1;
    in_valid = 3'b110;
    #1;
    chk("mrst_ack", 32'(in_ack), 32'd0);
    tick();
    rst      = 1'b0;
    in_valid = 3'b000;
    chk("mrst_valid", 32'(out_valid),    32'd0);
    chk("mrst_data",  32'(out_data),     32'd0);
    chk("mrst_mm",    32'(out_mismatch), 32'd0);
    chk("mrst_to",    32'(out_timeout),  32'd0);
    chk("mrst_fault", 32'(fault),        32'd0);
    seen_drop = 0;
    for (int i = 0; i < 8; i++) begin
      if (drop) seen_drop = 1;
      tick();
    end
    chk("mrst_nodrop", 32'(seen_drop), 32'd0);

    // Fault counters were cleared: one c mismatch leaves fault clear.
    vote_full("post", 8'h5A, 8'h5A, 8'hFF, 8'h5A, 3'b100, 3'b000);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  // Hard stop so the bench can never hang.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
